// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants and types for the 7-segment scan controller.
package seg7_scan_ctrl_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    typedef logic [BCD_W-1:0] bcd_t;
    typedef logic [SEG_W-1:0] seg_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam seg_t SEG_OFF = 7'b0;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } state_e;

    function automatic logic bcd_valid(input bcd_t v);
        return v <= BCD_MAX;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Producer-side digit bus and display pin bundle for the scan controller.
interface seg7_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    import seg7_scan_ctrl_pkg::*;

    logic [BCD_W*NUM_DIGITS-1:0] digits_in;
    logic                        load;
    logic                        lzb;
    logic [NUM_DIGITS-1:0]       an_n;
    seg_t                        seg_out;
    logic                        frame_done;

    modport master (
        output digits_in, load, lzb,
        input  an_n, seg_out, frame_done
    );

    modport slave (
        input  digits_in, load, lzb,
        output an_n, seg_out, frame_done
    );

endinterface

// File: rtl/seg7_scan_ctrl_bcd_to_7seg.sv
// BCD to 7-segment decoder, active-high segments {g,f,e,d,c,b,a}; invalid codes go dark.
module seg7_scan_ctrl_bcd_to_7seg
    import seg7_scan_ctrl_pkg::*;
(
    input  bcd_t bcd_i,
    output seg_t seg_c_o
);

    always_comb begin
        seg_c_o = SEG_OFF;
        if (bcd_valid(bcd_i)) begin
            case (bcd_i)
                4'd0:    seg_c_o = 7'h3F;
                4'd1:    seg_c_o = 7'h06;
                4'd2:    seg_c_o = 7'h5B;
                4'd3:    seg_c_o = 7'h4F;
                4'd4:    seg_c_o = 7'h66;
                4'd5:    seg_c_o = 7'h6D;
                4'd6:    seg_c_o = 7'h7D;
                4'd7:    seg_c_o = 7'h07;
                4'd8:    seg_c_o = 7'h7F;
                4'd9:    seg_c_o = 7'h6F;
                default: seg_c_o = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment display,
// with frame-aligned double buffering and leading-zero blanking.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SLOT_CYC   = 50000,
    parameter int unsigned BLANK_CYC  = 500
) (
    input  logic            clk,
    input  logic            rst_n,
    seg7_scan_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SLOT_END  = CNT_W'(SLOT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(NUM_DIGITS - 1);

    typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] buf_t;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    buf_t                  pend_q, pend_d;
    buf_t                  act_q, act_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [NUM_DIGITS-1:0] blank_q, blank_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    seg_t                  seg_q, seg_d;
    logic                  frame_done_q, frame_done_d;

    buf_t                  digits_c;
    buf_t                  commit_src_c;
    logic                  frame_end_c;
    logic                  commit_c;
    logic [NUM_DIGITS-1:0] lz_mask_c;
    bcd_t                  cur_bcd_c;
    seg_t                  dec_seg_c;

    assign digits_c  = buf_t'(bus.digits_in);
    assign cur_bcd_c = act_q[idx_q];

    seg7_scan_ctrl_bcd_to_7seg bcd_to_7seg (
        .bcd_i   (cur_bcd_c),
        .seg_c_o (dec_seg_c)
    );

    // Commit on the last cycle of the frame; a same-cycle load bypasses the pending buffer.
    always_comb begin
        frame_end_c  = (idx_q == IDX_LAST) && (cnt_q == CNT_SLOT_END);
        commit_c     = frame_end_c && (bus.load || pend_vld_q);
        commit_src_c = bus.load ? digits_c : pend_q;
    end

    // Leading zeros from the top digit down; digit 0 always stays lit.
    always_comb begin
        logic lead;
        lead      = bus.lzb;
        lz_mask_c = '0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            lead         = lead && (commit_src_c[k] == '0);
            lz_mask_c[k] = lead;
        end
    end

    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        act_d      = act_q;
        blank_d    = blank_q;
        if (bus.load) begin
            pend_d     = digits_c;
            pend_vld_d = 1'b1;
        end
        if (commit_c) begin
            act_d      = commit_src_c;
            blank_d    = lz_mask_c;
            pend_vld_d = 1'b0;
        end
    end

    // Slot sequencer and registered pin drive.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        an_n_d  = '1;
        seg_d   = dec_seg_c;
        case (state_q)
            BLANK: begin
                if (cnt_q == CNT_BLANK_END) begin
                    state_d = ON;
                end
            end
            ON: begin
                if (!blank_q[idx_q]) begin
                    an_n_d[idx_q] = 1'b0;
                end
                if (cnt_q == CNT_SLOT_END) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            end
            default: state_d = BLANK;
        endcase
        frame_done_d = (idx_d == IDX_LAST) && (cnt_d == CNT_SLOT_END);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            act_q        <= '0;
            blank_q      <= '0;
            an_n_q       <= '1;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            act_q        <= act_d;
            blank_q      <= blank_d;
            an_n_q       <= an_n_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.an_n       = an_n_q;
    assign bus.seg_out    = seg_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: table of committed frames plus load-race and reset sequences.
module tb_seg7_scan_ctrl;

    localparam int ND    = 4;
    localparam int SLOT  = 8;
    localparam int BLK   = 2;
    localparam int FRAME = ND * SLOT;
    localparam int NV    = 7;

    localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F, S4 = 7'h66;
    localparam logic [6:0] S5 = 7'h6D, S6 = 7'h7D, S7 = 7'h07, S8 = 7'h7F, S9 = 7'h6F;
    localparam logic [6:0] SX = 7'h00;

    typedef struct {
        logic [15:0]     digits;
        logic            lzb;
        logic [3:0][6:0] seg;
        logic [3:0]      lit;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) bus();

    seg7_scan_ctrl #(
        .NUM_DIGITS (ND),
        .SLOT_CYC   (SLOT),
        .BLANK_CYC  (BLK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    vec_t        tbl[NV];
    vec_t        idle;
    vec_t        v4321;
    int          n_ld;
    int          ld_p[3];
    logic [15:0] ld_v[3];
    logic        ld_z[3];

    function automatic vec_t mk(input logic [15:0] d, input logic z,
                                input logic [3:0][6:0] s, input logic [3:0] l);
        vec_t v;
        v.digits = d;
        v.lzb    = z;
        v.seg    = s;
        v.lit    = l;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int p, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s p=%0d got=%0h want=%0h", nm, p, act, exp);
        end
    endtask

    // Entered on the cycle after a frame_done cycle; checks the 32 output cycles of the
    // frame scanned from here and drives any scheduled loads at frame positions ld_p.
    task automatic check_frame(input vec_t e);
        for (int p = 0; p < FRAME; p++) begin
            int         k;
            int         c;
            logic [3:0] exp_an;
            step();
            bus.load = 1'b0;
            k = p / SLOT;
            c = p % SLOT;
            exp_an = (c < BLK || !e.lit[k]) ? 4'hF : ~(4'b0001 << k);
            chk("an_n", p, 32'(bus.an_n), 32'(exp_an));
            chk("seg_out", p, 32'(bus.seg_out), 32'(e.seg[k]));
            chk("frame_done", p, 32'(bus.frame_done), 32'(p == FRAME - 2));
            chk("one_anode", p, 32'($countones(~bus.an_n) <= 1), 32'd1);
            for (int j = 0; j < n_ld; j++) begin
                if (ld_p[j] == p) begin
                    bus.load      = 1'b1;
                    bus.digits_in = ld_v[j];
                    bus.lzb       = ld_z[j];
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.load      = 1'b0;
        bus.digits_in = '0;
        bus.lzb       = 1'b0;
        n_ld          = 0;

        tbl[0] = mk(16'h1234, 1'b0, {S1, S2, S3, S4}, 4'b1111);
        tbl[1] = mk(16'h0007, 1'b1, {S0, S0, S0, S7}, 4'b0001);
        tbl[2] = mk(16'h00A5, 1'b0, {S0, S0, SX, S5}, 4'b1111);
        tbl[3] = mk(16'h0A05, 1'b1, {S0, SX, S0, S5}, 4'b0111);
        tbl[4] = mk(16'h0000, 1'b1, {S0, S0, S0, S0}, 4'b0001);
        tbl[5] = mk(16'h8090, 1'b1, {S8, S0, S9, S0}, 4'b1111);
        tbl[6] = mk(16'h0600, 1'b1, {S0, S6, S0, S0}, 4'b0111);
        idle   = mk(16'h0000, 1'b0, {S0, S0, S0, S0}, 4'b1111);
        v4321  = mk(16'h4321, 1'b0, {S4, S3, S2, S1}, 4'b1111);

        repeat (3) step();
        chk("rst_an_n", -1, 32'(bus.an_n), 32'hF);
        chk("rst_seg", -1, 32'(bus.seg_out), 32'h0);
        chk("rst_frame_done", -1, 32'(bus.frame_done), 32'h0);
        rst_n = 1'b1;

        // Idle frame with the first table entry loaded mid-frame.
        n_ld = 1;
        ld_p[0] = 12; ld_v[0] = tbl[0].digits; ld_z[0] = tbl[0].lzb;
        check_frame(idle);

        for (int i = 0; i < NV; i++) begin
            if (i + 1 < NV) begin
                n_ld = 1;
                ld_p[0] = 12; ld_v[0] = tbl[i+1].digits; ld_z[0] = tbl[i+1].lzb;
            end else begin
                // Latest load wins, and a load on the frame_done cycle commits directly.
                n_ld = 3;
                ld_p[0] = 5;         ld_v[0] = 16'h1111; ld_z[0] = 1'b0;
                ld_p[1] = 15;        ld_v[1] = 16'h9999; ld_z[1] = 1'b0;
                ld_p[2] = FRAME - 2; ld_v[2] = 16'h4321; ld_z[2] = 1'b0;
            end
            check_frame(tbl[i]);
        end

        n_ld = 0;
        check_frame(v4321);

        // Reset pulse while idx=2, cnt=5.
        repeat (21) step();
        chk("pre_rst_an_n", 20, 32'(bus.an_n), 32'hB);
        chk("pre_rst_seg", 20, 32'(bus.seg_out), 32'(S3));
        rst_n = 1'b0;
        step();
        chk("midrst_an_n", 21, 32'(bus.an_n), 32'hF);
        chk("midrst_seg", 21, 32'(bus.seg_out), 32'h0);
        chk("midrst_frame_done", 21, 32'(bus.frame_done), 32'h0);
        rst_n = 1'b1;
        check_frame(idle);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
